seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving operand and quotient width.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port dividerbus, input, 2*WIDTH: dividend in [2*WIDTH-1:WIDTH], divisor in [WIDTH-1:0], both unsigned.
REQ-005 SHALL have port dividerres, output, WIDTH, the unsigned quotient.
REQ-006 SHALL have port dividercontrol, inout, 4: bit0 Ready (driven here), bit1 Busy (driven here), bit2 grant from the requesting master (read only), bit3 start (read only).
REQ-007 SHALL drive dividercontrol[1:0] at all times and never drive dividercontrol[3:2].

Function
REQ-008 SHALL implement three states: IDLE, RUN and DONE.
REQ-009 IDLE: Ready=1, Busy=0; the request is the condition "grant=1 and start=1", with any bit read as Z/X counting as 0.
REQ-010 IDLE with a request SHALL latch both operands from dividerbus, clear the remainder, load the iteration counter with WIDTH and go to RUN on the next edge.
REQ-011 RUN: Busy=1, Ready=0; one restoring-division step per cycle, MSB first: shift the remainder left with the next dividend bit, subtract the divisor if the result does not go negative, and shift the quotient bit in.
REQ-012 The remainder register SHALL be WIDTH+1 bits wide so that the subtract cannot overflow.
REQ-013 RUN SHALL last exactly WIDTH cycles; on the final step it SHALL write the quotient to dividerres and go to DONE.
REQ-014 Latency: request sampled at edge N -> Busy=1 from N+1 to N+WIDTH -> Ready=1 and dividerres valid from N+WIDTH+1.
REQ-015 DONE: Ready=1, Busy=0; dividerres SHALL hold its value until the next operation completes.
REQ-016 DONE SHALL go to IDLE only when start=0, so a start held high never re-triggers an operation.
REQ-017 Divisor 0 SHALL produce dividerres = all ones (0xFFFF at WIDTH=16) with normal timing: WIDTH cycles of Busy.
REQ-018 Dividend < divisor SHALL give 0; dividend 0 SHALL give 0.
REQ-019 Changes on dividerbus during RUN or DONE SHALL have no effect, because the operands are latched.
REQ-020 Start or grant dropping during RUN SHALL NOT abort the operation; it completes and enters DONE, then leaves DONE per REQ-016.
REQ-021 A request without grant=1 SHALL be ignored in every state.

Reset
REQ-022 rst_n=0 at a rising edge SHALL force IDLE and clear dividerres, the latched operands, the remainder and the counter to 0.
REQ-023 During and after reset, Ready SHALL be 1 and Busy SHALL be 0.
REQ-024 Reset asserted mid-RUN SHALL abandon the operation; no partial quotient reaches dividerres.
REQ-025 Reset SHALL have priority over every other transition.

Structure
REQ-026 A shared package SHALL hold:
- the state enumeration (IDLE/RUN/DONE);
- the WIDTH default;
- the dividercontrol bit indices (READY=0, BUSY=1, GRANT=2, START=3).
REQ-027 SHALL be a single module with no sub-module; the per-cycle step may be a local function.
REQ-028 SHALL contain no combinational path from dividerbus or dividercontrol to dividerres or to dividercontrol[1:0].

Verification
REQ-029 After reset release: dividercontrol[1:0]=2'b01 and dividerres=0.
REQ-030 Request with dividend 1000, divisor 7 -> Busy=1 for 16 cycles, then Ready=1 and dividerres=142 at N+17.
REQ-031 Operands 0xFFFF/1 -> 0xFFFF; operands 5/10 -> 0.
REQ-032 Divisor 0 with dividend 0x1234 -> dividerres=0xFFFF after 16 Busy cycles.
REQ-033 Start held high for 40 cycles with grant=1 -> exactly one operation, stays in DONE; start low, then high -> a second operation begins.
REQ-034 rst_n=0 at RUN cycle 8 -> IDLE next edge, dividerres=0, Ready=1; start=1 with grant=0 or Z -> no Busy pulse.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential restoring divider: default width,
// FSM state codes and the bit layout of the dividercontrol handshake bus.
package seq_divider_pkg;

    localparam int DIV_WIDTH = 16;

    typedef logic [1:0] div_state_t;

    localparam div_state_t ST_IDLE = 2'd0;
    localparam div_state_t ST_RUN  = 2'd1;
    localparam div_state_t ST_DONE = 2'd2;

    localparam int CTRL_READY = 0;
    localparam int CTRL_BUSY  = 1;
    localparam int CTRL_GRANT = 2;
    localparam int CTRL_START = 3;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider producing one quotient bit per clock, MSB first.
// Operands are captured on a granted start; Ready/Busy come straight from the state register.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2*WIDTH-1:0] dividerbus,
    output logic [WIDTH-1:0]   dividerres,
    inout  wire  [3:0]         dividercontrol
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       state;
    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH:0]   remainder;
    logic [CW-1:0]    count;

    logic             grant;
    logic             start;
    logic             request;
    logic             step_qbit;
    logic [WIDTH:0]   step_rem;

    // Returns {quotient bit, new remainder}; the extra top bit of the
    // difference acts as the borrow flag for the restore decision.
    function automatic logic [WIDTH+1:0] div_step(
        input logic [WIDTH:0]   rem,
        input logic             next_bit,
        input logic [WIDTH-1:0] divisor
    );
        logic [WIDTH+1:0] shifted;
        logic [WIDTH+1:0] diff;
        logic             qbit;
        shifted = {rem, next_bit};
        diff    = shifted - {2'b00, divisor};
        qbit    = ~diff[WIDTH+1];
        return {qbit, (qbit ? diff[WIDTH:0] : shifted[WIDTH:0])};
    endfunction

    assign grant   = dividercontrol[CTRL_GRANT];
    assign start   = dividercontrol[CTRL_START];
    assign request = grant & start;

    assign dividercontrol[CTRL_READY] = (state != ST_RUN);
    assign dividercontrol[CTRL_BUSY]  = (state == ST_RUN);

    always_comb begin
        {step_qbit, step_rem} = div_step(remainder, dividend_q[WIDTH-1], divisor_q);
    end

    // Quotient bits are shifted into the vacated low end of the dividend register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            dividerres <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            remainder  <= '0;
            count      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (request) begin
                        dividend_q <= dividerbus[2*WIDTH-1:WIDTH];
                        divisor_q  <= dividerbus[WIDTH-1:0];
                        remainder  <= '0;
                        count      <= CW'(WIDTH);
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    remainder  <= step_rem;
                    dividend_q <= {dividend_q[WIDTH-2:0], step_qbit};
                    count      <= count - CW'(1);
                    if (count == CW'(1)) begin
                        dividerres <= {dividend_q[WIDTH-2:0], step_qbit};
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!start) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model checked every
// cycle, plus directed operations with hand-computed quotients and busy counts.
module tb_seq_divider;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [2*W-1:0] bus = '0;
    logic [W-1:0]   res;
    wire  [3:0]     ctrl;

    logic grant_oe  = 1'b1;
    logic grant_drv = 1'b0;
    logic start_drv = 1'b0;

    assign ctrl[2] = grant_oe ? grant_drv : 1'bz;
    assign ctrl[3] = start_drv;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dividerbus     (bus),
        .dividerres     (res),
        .dividercontrol (ctrl)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                                 input logic grant, input logic start);
        bus       = {dvd, dvs};
        grant_drv = grant;
        start_drv = start;
    endtask

    function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? {W{1'b1}} : a / b;
    endfunction

    // Reference model: an accepted request yields W busy cycles, then the
    // arithmetic quotient is published and held until start is released.
    int           run_left = 0;
    bit           in_done  = 0;
    bit           model_on = 0;
    logic [W-1:0] exp_res  = '0;
    logic [W-1:0] pending  = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            run_left = 0;
            in_done  = 0;
            exp_res  = '0;
            model_on = 1;
        end else if (run_left > 0) begin
            run_left--;
            if (run_left == 0) begin
                exp_res = pending;
                in_done = 1;
            end
        end else if (in_done) begin
            if (start_drv !== 1'b1) in_done = 0;
        end else if (grant_oe && grant_drv === 1'b1 && start_drv === 1'b1) begin
            pending  = ref_div(bus[2*W-1:W], bus[W-1:0]);
            run_left = W;
        end
        #1;
        if (model_on) begin
            checkOutput("model ready/busy", {30'd0, ctrl[1:0]},
                        {30'd0, (run_left > 0), (run_left == 0)});
            checkOutput("model quotient", {16'd0, res}, {16'd0, exp_res});
        end
    end

    task automatic runOp(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         input logic [W-1:0] expq, input string name);
        int  busy_cnt;
        bit  done;
        busy_cnt = 0;
        done     = 0;
        @(negedge clk);
        applyStimulus(dvd, dvs, 1'b1, 1'b1);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start_drv = 1'b0;
                bus       = ~bus;
            end
            if (i == 2) grant_drv = 1'b0;
            if (ctrl[1] === 1'b1) busy_cnt++;
            else done = 1;
        end
        checkOutput({name, " finished"}, {31'd0, done}, 32'd1);
        checkOutput({name, " busy cycles"}, busy_cnt, 32'd16);
        checkOutput({name, " ready"}, {30'd0, ctrl[1:0]}, 32'd1);
        checkOutput({name, " quotient"}, {16'd0, res}, {16'd0, expq});
    endtask

    initial begin
        int  cnt;
        bit  seen;
        repeat (3) @(negedge clk);
        checkOutput("in reset ready/busy", {30'd0, ctrl[1:0]}, 32'd1);
        checkOutput("in reset quotient", {16'd0, res}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("after reset ready/busy", {30'd0, ctrl[1:0]}, 32'd1);
        checkOutput("after reset quotient", {16'd0, res}, 32'd0);

        runOp(16'd1000, 16'd7, 16'd142, "1000/7");
        repeat (3) @(negedge clk);
        checkOutput("quotient held", {16'd0, res}, 32'd142);
        runOp(16'hFFFF, 16'd1, 16'hFFFF, "FFFF/1");
        runOp(16'd5, 16'd10, 16'd0, "5/10");
        runOp(16'd0, 16'd3, 16'd0, "0/3");
        runOp(16'h1234, 16'd0, 16'hFFFF, "1234/0");
        runOp(16'd50000, 16'd300, 16'd166, "50000/300");

        // Start held high: exactly one operation, then parked in DONE.
        @(negedge clk);
        applyStimulus(16'd100, 16'd9, 1'b1, 1'b1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ctrl[1] === 1'b1) cnt++;
        end
        checkOutput("held start busy cycles", cnt, 32'd16);
        checkOutput("held start ready", {30'd0, ctrl[1:0]}, 32'd1);
        checkOutput("held start quotient", {16'd0, res}, 32'd11);
        start_drv = 1'b0;
        @(negedge clk);
        applyStimulus(16'd200, 16'd9, 1'b1, 1'b1);
        seen = 0;
        for (int i = 0; i < 3 && !seen; i++) begin
            @(negedge clk);
            if (ctrl[1] === 1'b1) seen = 1;
        end
        checkOutput("restart busy", {31'd0, seen}, 32'd1);
        start_drv = 1'b0;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (ctrl[1] === 1'b0) seen = 1;
        end
        checkOutput("restart finished", {31'd0, seen}, 32'd1);
        checkOutput("restart quotient", {16'd0, res}, 32'd22);

        // Reset in the middle of a run.
        @(negedge clk);
        applyStimulus(16'd60000, 16'd7, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        checkOutput("mid-run busy", {30'd0, ctrl[1:0]}, 32'd2);
        rst_n     = 1'b0;
        start_drv = 1'b0;
        @(negedge clk);
        checkOutput("mid-run reset ready/busy", {30'd0, ctrl[1:0]}, 32'd1);
        checkOutput("mid-run reset quotient", {16'd0, res}, 32'd0);
        rst_n = 1'b1;

        // Start without a valid grant must be ignored.
        @(negedge clk);
        grant_oe  = 1'b0;
        start_drv = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (ctrl[1] === 1'b1) cnt++;
        end
        checkOutput("grant Z no busy", cnt, 32'd0);
        grant_oe  = 1'b1;
        grant_drv = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (ctrl[1] === 1'b1) cnt++;
        end
        checkOutput("grant 0 no busy", cnt, 32'd0);
        start_drv = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
